// File: rtl/poly_eval_pkg.sv
// poly_eval_pkg: shared state encoding and protocol constants for the quadratic evaluator adapter.
package poly_eval_pkg;
   typedef enum logic [2:0] {IDLE, DRIVE_HI, DRIVE_LO, COMPUTE, OUT} state_t;
   localparam int IDX_W = 2;
   localparam int EVAL_MIN_COMPUTE = 6;
   localparam int GO_MIN_HIGH = 1;
   localparam int GO_MIN_LOW = 1;
endpackage

// File: rtl/poly_eval_go_driver.sv
// poly_eval_go_driver: holds the operand set and replays it as go/data_in press-release phases.
module poly_eval_go_driver
   import poly_eval_pkg::*;
#(
   parameter int GO_HIGH_CYCLES = GO_MIN_HIGH,
   parameter int GO_LOW_CYCLES = GO_MIN_LOW
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       load,
   input  logic       hi,
   input  logic       lo,
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic [7:0] c,
   input  logic [7:0] x,
   output logic       go,
   output logic [7:0] data_in,
   output logic       hi_done,
   output logic       lo_done,
   output logic       last
);
   localparam int CMAX = (GO_HIGH_CYCLES > GO_LOW_CYCLES) ? GO_HIGH_CYCLES : GO_LOW_CYCLES;
   localparam int CW = $clog2(CMAX + 1);
   logic [3:0][7:0]   ops;
   logic [IDX_W-1:0]  idx, idx_n;
   logic [CW-1:0]     cnt;
   assign idx_n   = idx + 1'b1;
   assign hi_done = cnt == CW'(GO_HIGH_CYCLES - 1);
   assign lo_done = cnt == CW'(GO_LOW_CYCLES - 1);
   assign last    = idx == IDX_W'(3);
   // data_in only moves when go rises, so it is stable across every go-high cycle
   always_ff @(posedge clk) begin
      if (!resetn) begin
         ops     <= '0;
         idx     <= '0;
         cnt     <= '0;
         go      <= 1'b0;
         data_in <= '0;
      end else if (load) begin
         ops     <= {x, c, b, a};
         idx     <= '0;
         cnt     <= '0;
         go      <= 1'b1;
         data_in <= a;
      end else if (hi) begin
         cnt <= hi_done ? '0 : cnt + 1'b1;
         go  <= !hi_done;
      end else if (lo) begin
         cnt <= lo_done ? '0 : cnt + 1'b1;
         if (lo_done) begin
            idx     <= idx_n;
            go      <= 1'b1;
            data_in <= ops[idx_n];
         end
      end
   end
endmodule

// File: rtl/poly_eval_sequencer.sv
// poly_eval_sequencer: valid/ready front-end and back-end adapter around the quadratic evaluator.
module poly_eval_sequencer
   import poly_eval_pkg::*;
#(
   parameter int GO_HIGH_CYCLES = 1,
   parameter int GO_LOW_CYCLES = 1,
   parameter int COMPUTE_CYCLES = EVAL_MIN_COMPUTE
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in_a,
   input  logic [7:0] in_b,
   input  logic [7:0] in_c,
   input  logic [7:0] in_x,
   output logic       go,
   output logic [7:0] data_in,
   input  logic [7:0] data_result,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] out_result,
   output logic       busy
);
   localparam int CCW = $clog2(COMPUTE_CYCLES + 1);
   state_t         state, nxt;
   logic [CCW-1:0] ccnt;
   logic           accept, hi_done, lo_done, last, c_done;
   assign in_ready = state == IDLE;
   assign busy     = !in_ready;
   assign accept   = in_valid && in_ready;
   assign c_done   = ccnt == CCW'(COMPUTE_CYCLES);
   poly_eval_go_driver #(
      .GO_HIGH_CYCLES(GO_HIGH_CYCLES),
      .GO_LOW_CYCLES (GO_LOW_CYCLES)
   ) u_drv (
      .clk    (clk),
      .resetn (resetn),
      .load   (accept),
      .hi     (state == DRIVE_HI),
      .lo     (state == DRIVE_LO),
      .a      (in_a),
      .b      (in_b),
      .c      (in_c),
      .x      (in_x),
      .go     (go),
      .data_in(data_in),
      .hi_done(hi_done),
      .lo_done(lo_done),
      .last   (last)
   );
   always_comb begin
      nxt = state;
      unique case (state)
         IDLE:     nxt = accept ? DRIVE_HI : IDLE;
         DRIVE_HI: nxt = !hi_done ? DRIVE_HI : (last ? COMPUTE : DRIVE_LO);
         DRIVE_LO: nxt = lo_done ? DRIVE_HI : DRIVE_LO;
         COMPUTE:  nxt = c_done ? OUT : COMPUTE;
         OUT:      nxt = out_ready ? IDLE : OUT;
         default:  nxt = IDLE;
      endcase
   end
   // the compute window spans COMPUTE_CYCLES+1 cycles, counted from the first go-low cycle after X
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state      <= IDLE;
         ccnt       <= '0;
         out_valid  <= 1'b0;
         out_result <= '0;
      end else begin
         state <= nxt;
         ccnt  <= (state == COMPUTE && !c_done) ? ccnt + 1'b1 : '0;
         if (state == COMPUTE && c_done) begin
            out_valid  <= 1'b1;
            out_result <= data_result;
         end else if (state == OUT && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_poly_eval_sequencer.sv
// tb_poly_eval_sequencer: directed vectors against a behavioural model of the part2 evaluator.
module tb_poly_eval_sequencer;
   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       in_valid = 1'b0, in_ready;
   logic [7:0] in_a = '0, in_b = '0, in_c = '0, in_x = '0;
   logic       go;
   logic [7:0] data_in, data_result, out_result;
   logic       out_valid, out_ready = 1'b0, busy;
   int         total = 0, passed = 0;

   typedef struct {
      logic [7:0] a, b, c, x, exp;
   } vec_t;
   vec_t vecs[3];

   always #5 clk = ~clk;

   poly_eval_sequencer dut (
      .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_x(in_x),
      .go(go), .data_in(data_in), .data_result(data_result),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .busy(busy)
   );

   // evaluator model: loads DataIn while Go is high, advances on Go falling, writes result at end of t+5
   logic [7:0] op [4];
   logic [1:0] ek;
   logic       go_q, ev_run;
   int         ev_cnt;
   always @(posedge clk) begin
      if (!resetn) begin
         go_q <= 1'b0; ek <= '0; ev_run <= 1'b0; ev_cnt <= 0; data_result <= '0;
      end else begin
         go_q <= go;
         if (go) op[ek] <= data_in;
         if (go_q && !go) begin
            ek <= ek + 1'b1;
            if (ek == 2'd3) begin
               ev_run <= 1'b1;
               ev_cnt <= 1;
               data_result <= ~(op[0] * op[3] * op[3] + op[1] * op[3] + op[2]);
            end
         end
         if (ev_run) begin
            if (ev_cnt == 5) begin
               ev_run <= 1'b0;
               data_result <= op[0] * op[3] * op[3] + op[1] * op[3] + op[2];
            end else ev_cnt <= ev_cnt + 1;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   function automatic logic [7:0] opnd(input vec_t v, input int i);
      return i == 0 ? v.a : i == 1 ? v.b : i == 2 ? v.c : v.x;
   endfunction

   task automatic run_set(input vec_t v);
      int k;
      in_a = v.a; in_b = v.b; in_c = v.c; in_x = v.x; in_valid = 1'b1;
      chk("in_ready_idle", in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0;
      k = 1;
      while (!out_valid && k < 40) begin
         chk("go_timing", go, (k % 2 == 1 && k <= 7));
         if (go) chk("data_in", data_in, opnd(v, (k - 1) / 2));
         chk("busy", busy, 1);
         @(negedge clk);
         k++;
      end
      chk("latency", k, 15);
      chk("result", out_result, v.exp);
   endtask

   task automatic finish_out();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("ready_after_hs", in_ready, 1);
      chk("valid_after_hs", out_valid, 0);
   endtask

   initial begin
      int k;
      logic [7:0] held;
      vecs[0] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd27};
      vecs[1] = '{8'd2, 8'd3, 8'd5, 8'd10, 8'd235};
      vecs[2] = '{8'd3, 8'd0, 8'd0, 8'd10, 8'd44};
      repeat (3) @(negedge clk);
      chk("rst_go", go, 0);
      chk("rst_data_in", data_in, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_result", out_result, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_busy", busy, 0);
      resetn = 1'b1;
      // out_ready with nothing pending must not disturb IDLE
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("stray_ready_idle", in_ready, 1);
      chk("stray_ready_valid", out_valid, 0);

      for (int i = 0; i < 3; i++) begin
         run_set(vecs[i]);
         if (i == 1) begin
            held = out_result;
            for (int j = 0; j < 20; j++) begin
               if (j == 5) begin
                  in_a = 8'd9; in_b = 8'd9; in_c = 8'd9; in_x = 8'd9; in_valid = 1'b1;
               end
               if (j == 6) in_valid = 1'b0;
               @(negedge clk);
               chk("bp_valid", out_valid, 1);
               chk("bp_result", out_result, held);
               chk("bp_in_ready", in_ready, 0);
            end
         end
         finish_out();
         if (i == 1) begin
            repeat (3) @(negedge clk);
            chk("no_queued_go", go, 0);
            chk("no_queued_busy", busy, 0);
         end
      end

      // back-to-back with in_valid held high
      in_a = 8'd1; in_b = 8'd2; in_c = 8'd3; in_x = 8'd4; in_valid = 1'b1;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!out_valid && k < 40);
      chk("b2b_latency1", k, 15);
      chk("b2b_result1", out_result, 27);
      in_a = 8'd0; in_b = 8'd0; in_c = 8'd7; in_x = 8'd9; out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("b2b_ready", in_ready, 1);
      chk("b2b_valid_low", out_valid, 0);
      @(negedge clk);
      in_valid = 1'b0;
      chk("b2b_accept_go", go, 1);
      chk("b2b_accept_a", data_in, 0);
      chk("b2b_busy", in_ready, 0);
      k = 1;
      while (!out_valid && k < 40) begin
         @(negedge clk);
         k++;
      end
      chk("b2b_latency2", k, 15);
      chk("b2b_result2", out_result, 7);
      finish_out();

      // reset during the C go-high phase
      in_a = 8'd5; in_b = 8'd6; in_c = 8'd7; in_x = 8'd8; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (4) @(negedge clk);
      chk("mid_c_go", go, 1);
      chk("mid_c_data", data_in, 7);
      resetn = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      chk("mid_rst_go", go, 0);
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_ready", in_ready, 1);
      chk("mid_rst_data", data_in, 0);
      k = 0;
      for (int j = 0; j < 20; j++) begin
         @(negedge clk);
         if (out_valid || go) k++;
      end
      chk("aborted_silent", k, 0);
      run_set('{8'd1, 8'd1, 8'd1, 8'd1, 8'd3});
      finish_out();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end
endmodule
